// File: rtl/rv_wb_pkg.sv
// Shared types and widths for the register-file write-side front end.
package rv_wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // One pending register-file write: destination index plus result.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of long-latency writeback requests.
// Pointers carry an extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  logic    pop_i,
    input  wb_req_t wdata_i,
    output wb_req_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wb_req_t     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        full_s;
    logic        empty_s;
    logic        push_ok_s;
    logic        pop_ok_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    // Pointer advance; a write into a full FIFO is refused so no entry is lost.
    always_comb begin
        push_ok_s = push_i && !full_s;
        pop_ok_s  = pop_i && !empty_s;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // Pointer registers; reset drops every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, cleared on reset so no stale result can ever be read out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {($bits(wb_req_t)){1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-port owner: merges in-order pipeline writeback with
// buffered long-latency results and tracks outstanding destinations so decode
// can stall on RAW/WAW hazards.
// Optional build macro WB_BYPASS_EN: when the FIFO is empty and the pipeline
// leaves the port free, a long-latency result is written in its arrival cycle.
// XLEN must match rv_wb_pkg::XLEN (the buffered request type uses the package width).
module reg_writeback_unit
    import rv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = rv_wb_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lat_valid,
    input  logic [4:0]      lat_rd,
    input  logic [XLEN-1:0] lat_data,
    output logic            lat_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending
);

    logic            pipe_sel_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    wb_req_t         head_s;
    wb_req_t         push_req_s;
    logic            lat_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            bypass_s;
    logic            rf_we_s;
    logic [4:0]      rf_waddr_s;
    logic [XLEN-1:0] rf_wdata_s;
    logic [31:0]     clr_mask_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     pending_q;
    logic [31:0]     pending_d;

    // A pipeline write to x0 is a no-op and leaves the port to the FIFO.
    assign pipe_sel_s  = pipe_we && (pipe_rd != 5'd0);

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign lat_ready_s = rst_n && !fifo_full_s;

    // Write-port arbitration: pipeline first, then FIFO head, then (optionally) bypass.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = {XLEN{1'b0}};
        pop_s      = 1'b0;
        bypass_s   = 1'b0;
        if (!rst_n) begin
            rf_we_s = 1'b0;
        end else if (pipe_sel_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = pipe_rd;
            rf_wdata_s = pipe_data;
        end else if (!fifo_empty_s) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = head_s.rd;
            rf_wdata_s = head_s.data;
            pop_s      = 1'b1;
`ifdef WB_BYPASS_EN
        end else if (lat_valid && (lat_rd != 5'd0)) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = lat_rd;
            rf_wdata_s = lat_data;
            bypass_s   = 1'b1;
`endif
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Results for x0 are accepted but never buffered; bypassed results skip the FIFO.
    always_comb begin
        push_req_s.rd   = lat_rd;
        push_req_s.data = lat_data;
        push_s          = lat_valid && lat_ready_s && (lat_rd != 5'd0) && !bypass_s;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (push_req_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Scoreboard next state: clear on long-latency write, then set on issue so set wins.
    always_comb begin
        clr_mask_s = (pop_s || bypass_s) ? (32'd1 << rf_waddr_s) : 32'd0;
        set_mask_s = (iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
        pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // Scoreboard register; reset forgets every outstanding result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign stall     = rst_n && (pending_q[rs1] || pending_q[rs2] ||
                                 (iss_valid && pending_q[iss_rd]));
    assign lat_ready = lat_ready_s;
    assign rf_we     = rf_we_s;
    assign rf_waddr  = rf_waddr_s;
    assign rf_wdata  = rf_wdata_s;
    assign pending   = pending_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit (DEPTH=2, XLEN=32).
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        lat_valid = 1'b0;
    logic [4:0]  lat_rd = 5'd0;
    logic [31:0] lat_data = 32'd0;
    logic        lat_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t pipe_q[$];
    exp_t lat_q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_writeback_unit #(.DEPTH(2), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .lat_valid (lat_valid),
        .lat_rd    (lat_rd),
        .lat_data  (lat_data),
        .lat_ready (lat_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pending   (pending)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the scoreboard.
    // A live pipeline write owns the port; any other write must be the oldest
    // expected long-latency result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pipe_we && (pipe_rd != 5'd0)) begin
                    if (pipe_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pipe_sb: no expected pipeline write for rd %0d", pipe_rd);
                    end else begin
                        e = pipe_q.pop_front();
                        chk("pipe_we", 32'(rf_we), 32'd1);
                        chk("pipe_waddr", 32'(rf_waddr), 32'(e.rd));
                        chk("pipe_wdata", rf_wdata, e.data);
                    end
                end else if (rf_we) begin
                    if (lat_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL lat_sb: unexpected write rd %0d data 0x%08h", rf_waddr, rf_wdata);
                    end else begin
                        e = lat_q.pop_front();
                        chk("lat_waddr", 32'(rf_waddr), 32'(e.rd));
                        chk("lat_wdata", rf_wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        lat_valid = 1'b0; lat_rd = 5'd0; lat_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        pipe_we = 1'b1; pipe_rd = rd; pipe_data = d;
        e.rd = rd; e.data = d;
        if (rd != 5'd0) pipe_q.push_back(e);
    endtask

    // exp_wr: this result is accepted this cycle and will reach the register file.
    task automatic lat(input logic [4:0] rd, input logic [31:0] d, input bit exp_wr);
        exp_t e;
        lat_valid = 1'b1; lat_rd = rd; lat_data = d;
        e.rd = rd; e.data = d;
        if (exp_wr) lat_q.push_back(e);
    endtask

    task automatic iss(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd = rd;
    endtask

    initial begin
        // Reset state, with a pipeline write attempted while held in reset.
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1111_1111;
        mid();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_lat_ready", 32'(lat_ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pending", pending, 32'd0);
        cyc_begin();
        rst_n = 1'b1;
        mid();
        chk("post_rst_lat_ready", 32'(lat_ready), 32'd1);

        // Pipeline write lands in the same cycle.
        cyc_begin(); pipe(5'd5, 32'hDEAD_BEEF); mid();
        chk("pipe_same_cycle_we", 32'(rf_we), 32'd1);
        chk("pipe_same_cycle_addr", 32'(rf_waddr), 32'd5);

        // Issue rd=7, hazard on rs1, result pushed, written next cycle, stall drops after.
        cyc_begin(); iss(5'd7); mid();
        chk("iss7_no_stall", 32'(stall), 32'd0);
        cyc_begin(); rs1 = 5'd7; pipe(5'd30, 32'h0000_0030); lat(5'd7, 32'h0000_1234, 1'b1); mid();
        chk("raw7_stall", 32'(stall), 32'd1);
        chk("pending7", pending, 32'h0000_0080);
        cyc_begin(); rs1 = 5'd7; mid();
        chk("pop7_we", 32'(rf_we), 32'd1);
        chk("pop7_stall_held", 32'(stall), 32'd1);
        cyc_begin(); rs1 = 5'd7; mid();
        chk("after7_stall", 32'(stall), 32'd0);
        chk("after7_pending", pending, 32'd0);

        // Continuous pipeline writes while three results arrive; FIFO fills, then drains in order.
        cyc_begin(); pipe(5'd10, 32'hA000_0000); lat(5'd11, 32'hB000_0000, 1'b1); mid();
        chk("fill_ready0", 32'(lat_ready), 32'd1);
        cyc_begin(); pipe(5'd12, 32'hA000_0001); lat(5'd13, 32'hB000_0001, 1'b1); mid();
        chk("fill_ready1", 32'(lat_ready), 32'd1);
        cyc_begin(); pipe(5'd14, 32'hA000_0002); lat(5'd15, 32'hB000_0002, 1'b0); mid();
        chk("fill_full", 32'(lat_ready), 32'd0);
        cyc_begin(); lat(5'd15, 32'hB000_0002, 1'b0); mid();
        chk("drain_full_ready", 32'(lat_ready), 32'd0);
        chk("drain_first_we", 32'(rf_we), 32'd1);
        cyc_begin(); lat(5'd15, 32'hB000_0002, 1'b1); mid();
        chk("drain_ready_again", 32'(lat_ready), 32'd1);
        cyc_begin(); mid();
        chk("drain_last_we", 32'(rf_we), 32'd1);
        cyc_begin(); mid();
        chk("drain_idle_we", 32'(rf_we), 32'd0);
        chk("drain_lat_q", 32'(lat_q.size()), 32'd0);

        // Re-issue to a pending register stalls; pop and issue of rd=9 together keep the bit.
        cyc_begin(); iss(5'd9); mid();
        cyc_begin(); iss(5'd9); pipe(5'd31, 32'h0000_0031); lat(5'd9, 32'h0000_0099, 1'b1); mid();
        chk("waw9_stall", 32'(stall), 32'd1);
        cyc_begin(); iss(5'd9); mid();
        chk("pop9_stall", 32'(stall), 32'd1);
        chk("pop9_we", 32'(rf_we), 32'd1);
        cyc_begin(); pipe(5'd1, 32'h0000_0001); lat(5'd9, 32'h0000_009A, 1'b1); mid();
        chk("set_wins_pending9", pending, 32'h0000_0200);
        cyc_begin(); mid();
        cyc_begin(); mid();
        chk("clear9_pending", pending, 32'd0);

        // pipe_rd=0 yields the port to the FIFO; lat_rd=0 is accepted and dropped.
        cyc_begin(); pipe(5'd20, 32'h0000_0A20); lat(5'd3, 32'h0000_0033, 1'b1); mid();
        cyc_begin(); pipe(5'd0, 32'h0000_0BAD); lat(5'd0, 32'h0000_0055, 1'b0); mid();
        chk("x0_fifo_we", 32'(rf_we), 32'd1);
        chk("x0_fifo_addr", 32'(rf_waddr), 32'd3);
        chk("x0_fifo_data", rf_wdata, 32'h0000_0033);
        chk("lat_x0_ready", 32'(lat_ready), 32'd1);
        cyc_begin(); mid();
        chk("lat_x0_no_write", 32'(rf_we), 32'd0);
        chk("lat_x0_ready_after", 32'(lat_ready), 32'd1);

        // Reset with two buffered entries and pending bits: everything is dropped.
        cyc_begin(); iss(5'd21); mid();
        cyc_begin(); iss(5'd22); mid();
        cyc_begin(); pipe(5'd23, 32'h0000_0023); lat(5'd21, 32'h0000_2121, 1'b0); mid();
        cyc_begin(); pipe(5'd24, 32'h0000_0024); lat(5'd22, 32'h0000_2222, 1'b0); mid();
        cyc_begin(); pipe(5'd25, 32'h0000_0025); mid();
        chk("pre_rst_full", 32'(lat_ready), 32'd0);
        chk("pre_rst_pending", pending, 32'h0060_0000);
        cyc_begin();
        rst_n = 1'b0;
        pipe_we = 1'b1; pipe_rd = 5'd26; pipe_data = 32'h0000_0026;
        rs1 = 5'd21; iss_valid = 1'b1; iss_rd = 5'd22;
        mid();
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_lat_ready", 32'(lat_ready), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        cyc_begin(); rst_n = 1'b0; mid();
        cyc_begin(); rst_n = 1'b1; mid();
        chk("rel_lat_ready", 32'(lat_ready), 32'd1);
        chk("rel_pending", pending, 32'd0);
        chk("rel_rf_we", 32'(rf_we), 32'd0);
        cyc_begin(); mid();
        cyc_begin(); mid();

        // Long-latency result arriving with an empty FIFO and an idle pipeline.
        cyc_begin(); iss(5'd4); mid();
        cyc_begin(); lat(5'd4, 32'h0000_0044, 1'b1); mid();
`ifdef WB_BYPASS_EN
        chk("bypass_we", 32'(rf_we), 32'd1);
        chk("bypass_addr", 32'(rf_waddr), 32'd4);
`else
        chk("nobypass_we", 32'(rf_we), 32'd0);
        cyc_begin(); mid();
        chk("nobypass_later_we", 32'(rf_we), 32'd1);
`endif
        cyc_begin(); mid();
        chk("lat4_pending", pending, 32'd0);

        chk("end_pipe_q", 32'(pipe_q.size()), 32'd0);
        chk("end_lat_q", 32'(lat_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
